// File: rtl/rv32v_load_collector.sv
// ---------------------------------------------------------------------------
// rv32v_load_collector
//
// Gathers the per-lane results of one vector load uop. The load/store cluster
// (LSC) returns one raw 32-bit word per active lane, in ascending lane order.
// This block extracts the element from each word according to the element
// width, zero-extends it, and stores it in that lane's slot. When every
// active lane has been filled, it presents the assembled 128-bit result to
// writeback and holds it until writeback accepts it.
//
// Ports
//   CLK              clock; all state changes on its rising edge
//   RST              asynchronous, active-high reset
//   start            one-cycle pulse: a new uop begins (accepted only in IDLE)
//   lane_mask        active lanes of the uop, sampled on an accepted start
//   veew             element width: 0=8b, 1=16b, 2/3=32b, sampled on start
//   flush            abandon the current uop; overrides every other input
//   rsp_valid        LSC response valid for lane exp_lane
//   rsp_data         raw word returned by the LSC
//   rsp_byte_offset  address bits [1:0] of the returned element
//   exp_lane         lane whose response is expected next (0 outside COLLECT)
//   busy             high whenever the collector is not IDLE
//   wb_valid         assembled result available
//   wb_ready         writeback accepts the result
//   wb_data          lane i element in bits [32i+31:32i]
//   wb_mask          lane mask latched for the uop, aligned with wb_data
// ---------------------------------------------------------------------------
module rv32v_load_collector #(
  parameter int NUM_LANES = 4  // only 4 lanes are supported
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start,
  input  logic [NUM_LANES-1:0]    lane_mask,
  input  logic [1:0]              veew,
  input  logic                    flush,
  input  logic                    rsp_valid,
  input  logic [31:0]             rsp_data,
  input  logic [1:0]              rsp_byte_offset,
  output logic [1:0]              exp_lane,
  output logic                    busy,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [32*NUM_LANES-1:0] wb_data,
  output logic [NUM_LANES-1:0]    wb_mask
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WB      = 2'd2
  } state_t;

  localparam logic [1:0] EEW8  = 2'd0;
  localparam logic [1:0] EEW16 = 2'd1;

  state_t                state_q;
  state_t                state_d;
  logic [NUM_LANES-1:0]  mask_q;
  logic [1:0]            veew_q;
  logic [1:0]            lane_q;
  logic [31:0]           slot_q [NUM_LANES];

  logic [1:0]            first_lane;
  logic [1:0]            next_lane;
  logic                  has_next;
  logic [31:0]           byte_shifted;
  logic [31:0]           half_shifted;
  logic [31:0]           elem;

  // -------------------------------------------------------------------------
  // Lane selection helpers
  // -------------------------------------------------------------------------

  // Lowest set bit of the incoming mask: the first lane to collect.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    first_lane = 2'd0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_mask[i]) first_lane = 2'(i);
    end
  end

  // Next set bit strictly above the current lane. Masked lanes are skipped
  // here combinationally, so they never cost a cycle.
  always_comb begin
    has_next  = 1'b0;
    next_lane = lane_q;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(lane_q))) begin
        has_next  = 1'b1;
        next_lane = 2'(i);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Element extraction from the raw LSC word
  // -------------------------------------------------------------------------
  // Byte: shift by offset*8. Halfword: shift by offset[1]*16, so offset[0]
  // plays no part. Word: the offset is ignored entirely.
  always_comb begin
    byte_shifted = rsp_data >> {rsp_byte_offset, 3'b000};
    half_shifted = rsp_data >> {rsp_byte_offset[1], 4'b0000};
    case (veew_q)
      EEW8:    elem = {24'd0, byte_shifted[7:0]};
      EEW16:   elem = {16'd0, half_shifted[15:0]};
      default: elem = rsp_data;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          // An empty mask has nothing to collect: go straight to writeback.
          if (start) state_d = (|lane_mask) ? S_COLLECT : S_WB;
        end
        S_COLLECT: begin
          if (rsp_valid && !has_next) state_d = S_WB;
        end
        S_WB: begin
          if (wb_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers: latched uop parameters, expected lane, lane slots
  // -------------------------------------------------------------------------
  // Slots are only touched on an accepted start (cleared), a response in
  // COLLECT (one slot written) or a flush (cleared), so wb_data is stable
  // for as long as the result waits in WB.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mask_q <= '0;
      veew_q <= 2'd0;
      lane_q <= 2'd0;
      // NOTE: the slot array is reset explicitly; it is small and wb_data
      // must read zero straight out of reset, so it stays in flops rather
      // than a RAM macro.
      for (int i = 0; i < NUM_LANES; i++) slot_q[i] <= 32'd0;
    end else if (flush) begin
      mask_q <= '0;
      lane_q <= 2'd0;
      for (int i = 0; i < NUM_LANES; i++) slot_q[i] <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mask_q <= lane_mask;
            veew_q <= veew;
            lane_q <= first_lane;
            for (int i = 0; i < NUM_LANES; i++) slot_q[i] <= 32'd0;
          end
        end
        S_COLLECT: begin
          if (rsp_valid) begin
            slot_q[lane_q] <= elem;
            if (has_next) lane_q <= next_lane;
          end
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    exp_lane = (state_q == S_COLLECT) ? lane_q : 2'd0;
    busy     = (state_q != S_IDLE);
    wb_valid = (state_q == S_WB);
    wb_mask  = mask_q;
    wb_data  = '0;
    for (int i = 0; i < NUM_LANES; i++) wb_data[32*i +: 32] = slot_q[i];
  end

endmodule

// File: tb/tb_rv32v_load_collector.sv
// ---------------------------------------------------------------------------
// tb_rv32v_load_collector
//
// Directed scenarios followed by randomized uops. A behavioural model tracks
// the uop as a queue of lanes still awaiting data plus an array of lane
// values; every cycle the DUT outputs are compared against it, and the
// directed scenarios add literal expected values on top.
// ---------------------------------------------------------------------------
module tb_rv32v_load_collector;

  logic         CLK = 1'b0;
  logic         RST;
  logic         start;
  logic [3:0]   lane_mask;
  logic [1:0]   veew;
  logic         flush;
  logic         rsp_valid;
  logic [31:0]  rsp_data;
  logic [1:0]   rsp_byte_offset;
  logic [1:0]   exp_lane;
  logic         busy;
  logic         wb_valid;
  logic         wb_ready;
  logic [127:0] wb_data;
  logic [3:0]   wb_mask;

  int checks   = 0;
  int failures = 0;

  rv32v_load_collector #(.NUM_LANES(4)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .start           (start),
    .lane_mask       (lane_mask),
    .veew            (veew),
    .flush           (flush),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .rsp_byte_offset (rsp_byte_offset),
    .exp_lane        (exp_lane),
    .busy            (busy),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .wb_data         (wb_data),
    .wb_mask         (wb_mask)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  int          pend[$];      // lanes still waiting for a response, in order
  bit          m_wbv;        // a finished result is waiting for writeback
  logic [31:0] m_slot[4];
  logic [3:0]  m_mask;
  logic [1:0]  m_veew;

  function automatic logic [31:0] model_elem(input logic [31:0] data,
                                             input int off, input int w);
    if (w == 0) return (data >> (8 * off)) & 32'h0000_00FF;
    if (w == 1) return (data >> (16 * (off / 2))) & 32'h0000_FFFF;
    return data;
  endfunction

  function automatic void reset_model();
    pend.delete();
    m_wbv  = 1'b0;
    m_mask = 4'd0;
    m_veew = 2'd0;
    for (int i = 0; i < 4; i++) m_slot[i] = 32'd0;
  endfunction

  // Applies the current inputs to the model as one clock edge.
  function automatic void model_edge();
    if (flush) begin
      pend.delete();
      m_wbv  = 1'b0;
      m_mask = 4'd0;
      for (int i = 0; i < 4; i++) m_slot[i] = 32'd0;
    end else if (pend.size() != 0) begin
      if (rsp_valid) begin
        m_slot[pend[0]] = model_elem(rsp_data, int'(rsp_byte_offset), int'(m_veew));
        void'(pend.pop_front());
        if (pend.size() == 0) m_wbv = 1'b1;
      end
    end else if (m_wbv) begin
      if (wb_ready) m_wbv = 1'b0;
    end else if (start) begin
      m_mask = lane_mask;
      m_veew = veew;
      for (int i = 0; i < 4; i++) m_slot[i] = 32'd0;
      for (int i = 0; i < 4; i++) if (lane_mask[i]) pend.push_back(i);
      if (pend.size() == 0) m_wbv = 1'b1;
    end
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int e;
    bit b;
    e = (pend.size() != 0) ? pend[0] : 0;
    b = (pend.size() != 0) || m_wbv;
    check("exp_lane", 128'(exp_lane), 128'(e));
    check("busy",     128'(busy),     128'(b));
    check("wb_valid", 128'(wb_valid), 128'(m_wbv));
    check("wb_mask",  128'(wb_mask),  128'(m_mask));
    check("wb_data",  wb_data, {m_slot[3], m_slot[2], m_slot[1], m_slot[0]});
  endtask

  // One clock cycle: drive inputs, advance model, take the edge, compare.
  task automatic cyc(input logic st, input logic [3:0] m, input logic [1:0] w,
                     input logic fl, input logic rv, input logic [31:0] d,
                     input logic [1:0] off, input logic wr);
    start           = st;
    lane_mask       = m;
    veew            = w;
    flush           = fl;
    rsp_valid       = rv;
    rsp_data        = d;
    rsp_byte_offset = off;
    wb_ready        = wr;
    model_edge();
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic idle_cyc(input logic wr);
    cyc(1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 32'd0, 2'd0, wr);
  endtask

  task automatic rsp(input logic [31:0] d, input logic [1:0] off);
    cyc(1'b0, 4'd0, 2'd0, 1'b0, 1'b1, d, off, 1'b0);
  endtask

  initial begin
    RST             = 1'b1;
    start           = 1'b0;
    lane_mask       = 4'd0;
    veew            = 2'd0;
    flush           = 1'b0;
    rsp_valid       = 1'b0;
    rsp_data        = 32'd0;
    rsp_byte_offset = 2'd0;
    wb_ready        = 1'b0;
    reset_model();
    #3;
    check_all();                              // reset state
    #9 RST = 1'b0;                            // released between edges

    // Four-lane 32-bit uop; start honored on first edge after release.
    cyc(1'b1, 4'hF, 2'd2, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0);
    check("d1_lane0", 128'(exp_lane), 128'd0);
    rsp(32'hA, 2'd1);
    check("d1_lane1", 128'(exp_lane), 128'd1);
    rsp(32'hB, 2'd2);
    rsp(32'hC, 2'd3);
    check("d1_lane3", 128'(exp_lane), 128'd3);
    rsp(32'hD, 2'd0);
    check("d1_wbv", 128'(wb_valid), 128'd1);
    check("d1_data", wb_data, {32'hD, 32'hC, 32'hB, 32'hA});
    check("d1_mask", 128'(wb_mask), 128'hF);
    // Accept with a coincident start: the start must be ignored.
    cyc(1'b1, 4'h3, 2'd0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b1);
    check("d1_idle", 128'(busy), 128'd0);
    idle_cyc(1'b0);

    // Bytes on sparse lanes; a response alongside start is ignored.
    cyc(1'b1, 4'h5, 2'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 2'd0, 1'b0);
    rsp(32'h1122_3344, 2'd2);
    check("d2_lane2", 128'(exp_lane), 128'd2);
    idle_cyc(1'b0);                           // gap: everything holds
    rsp(32'h5566_7788, 2'd3);
    check("d2_data", wb_data, {32'h0, 32'h55, 32'h0, 32'h22});
    idle_cyc(1'b1);

    // Empty mask: straight to writeback, held while wb_ready is low.
    cyc(1'b1, 4'h0, 2'd2, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0);
    check("d3_wbv", 128'(wb_valid), 128'd1);
    repeat (3) idle_cyc(1'b0);
    check("d3_busy", 128'(busy), 128'd1);
    check("d3_data", wb_data, 128'd0);
    idle_cyc(1'b1);

    // Halfword at offset 3 takes the upper half.
    cyc(1'b1, 4'h2, 2'd1, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0);
    check("d4_lane1", 128'(exp_lane), 128'd1);
    rsp(32'hBEEF_1234, 2'd3);
    check("d4_data", wb_data, {32'h0, 32'h0, 32'h0000_BEEF, 32'h0});
    idle_cyc(1'b1);

    // Flush mid-collect with rsp_valid, start and wb_ready also high.
    cyc(1'b1, 4'hF, 2'd2, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0);
    rsp(32'h1111_1111, 2'd0);
    rsp(32'h2222_2222, 2'd0);
    cyc(1'b1, 4'hF, 2'd2, 1'b1, 1'b1, 32'h3333_3333, 2'd0, 1'b1);
    check("d5_flush_busy", 128'(busy), 128'd0);
    check("d5_flush_mask", 128'(wb_mask), 128'd0);
    idle_cyc(1'b0);
    cyc(1'b1, 4'hF, 2'd3, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) rsp(32'h100 + 32'(i), 2'd0);
    check("d5_data", wb_data, {32'h103, 32'h102, 32'h101, 32'h100});
    idle_cyc(1'b1);

    // Asynchronous reset between edges in the middle of a collect.
    cyc(1'b1, 4'hF, 2'd0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0);
    rsp(32'hCAFE_F00D, 2'd1);
    #2 RST = 1'b1;
    #1;
    reset_model();
    check("d6_rst_busy", 128'(busy), 128'd0);
    check("d6_rst_wbv", 128'(wb_valid), 128'd0);
    check_all();
    repeat (2) begin
      @(posedge CLK);
      #1;
      check_all();
    end
    RST = 1'b0;
    idle_cyc(1'b0);                           // no stray wb_valid after release
    cyc(1'b1, 4'h9, 2'd1, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0);
    rsp(32'hABCD_9876, 2'd1);
    rsp(32'hABCD_9876, 2'd2);
    check("d6_data", wb_data, {32'h0000_ABCD, 32'h0, 32'h0, 32'h0000_9876});
    idle_cyc(1'b1);

    // Randomized uops against the model.
    for (int u = 0; u < 60; u++) begin
      int n;
      cyc(1'b1, 4'($urandom), 2'($urandom), 1'b0, 1'($urandom),
          $urandom, 2'($urandom), 1'($urandom));
      n = 0;
      while ((pend.size() != 0 || m_wbv) && n < 300) begin
        cyc(1'($urandom_range(0, 3) == 0), 4'($urandom), 2'($urandom),
            1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 9) < 6),
            $urandom, 2'($urandom), 1'($urandom_range(0, 2) == 0));
        n++;
      end
      checks++;
      assert (n < 300) else begin
        failures++;
        $error("FAIL rand_budget: observed=%0d cycles expected=<300", n);
      end
      if (($urandom % 2) == 0) idle_cyc(1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
